// File: rtl/fxp_divider_pkg.sv
// fxp_divider_pkg: shared fixed-point defaults and divider FSM encoding
package fxp_divider_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int FRAC_DEF   = 15;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

endpackage

// File: rtl/fxp_div_step.sv
// fxp_div_step: one combinational restoring-division step on unsigned magnitudes
module fxp_div_step #(
    parameter int DWIDTH = 16
) (
    input  logic [DWIDTH-1:0] rem_in,
    input  logic              bit_in,
    input  logic [DWIDTH-1:0] den,
    output logic [DWIDTH-1:0] rem_out,
    output logic              q_bit
);

    logic [DWIDTH:0]   sh;
    logic [DWIDTH-1:0] diff;

    // the remainder stays below den, so the difference always fits in DWIDTH bits
    assign sh      = {rem_in, bit_in};
    assign diff    = sh[DWIDTH-1:0] - den;
    assign q_bit   = sh >= {1'b0, den};
    assign rem_out = q_bit ? diff : sh[DWIDTH-1:0];

endmodule

// File: rtl/fxp_divider.sv
// fxp_divider: sequential signed fixed-point divider, one quotient bit per clock
module fxp_divider
    import fxp_divider_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int FRAC   = FRAC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] num,
    input  logic [DWIDTH-1:0] den,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] quot,
    output logic              sat,
    output logic              div0
);

    localparam int QW = DWIDTH + FRAC;
    localparam int CW = $clog2(QW + 1);
    localparam logic [QW-1:0]     POS_LIM = {{(FRAC + 1){1'b0}}, {(DWIDTH - 1){1'b1}}};
    localparam logic [QW-1:0]     NEG_LIM = POS_LIM + 1'b1;
    localparam logic [DWIDTH-1:0] Q_MAX   = {1'b0, {(DWIDTH - 1){1'b1}}};
    localparam logic [DWIDTH-1:0] Q_MIN   = {1'b1, {(DWIDTH - 1){1'b0}}};

    state_t            state, state_nx;
    logic              sign, num_neg, zero_den, q_bit, last, ovf;
    logic [DWIDTH-1:0] num_mag, den_mag_in, den_mag, rem, rem_nx, q_lo, res;
    logic [QW-1:0]     acc;
    logic [CW-1:0]     iter;

    assign in_ready   = rst_n && state == IDLE;
    assign num_mag    = num[DWIDTH-1] ? -num : num;
    assign den_mag_in = den[DWIDTH-1] ? -den : den;
    assign last       = iter == CW'(QW - 1);

    // acc holds the shifted dividend; quotient bits fill it from the bottom
    fxp_div_step #(.DWIDTH(DWIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (acc[QW-1]),
        .den     (den_mag),
        .rem_out (rem_nx),
        .q_bit   (q_bit)
    );

    assign q_lo = acc[DWIDTH-1:0];
    assign ovf  = acc > (sign ? NEG_LIM : POS_LIM);
    assign res  = zero_den ? (num_neg ? Q_MIN : Q_MAX) :
                  ovf      ? (sign ? Q_MIN : Q_MAX)    :
                  sign     ? -q_lo : q_lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid) state_nx = (den == '0) ? FIX : CALC;
            CALC: if (last) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: if (out_valid && out_ready) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign      <= 1'b0;
            num_neg   <= 1'b0;
            zero_den  <= 1'b0;
            den_mag   <= '0;
            rem       <= '0;
            acc       <= '0;
            iter      <= '0;
            quot      <= '0;
            sat       <= 1'b0;
            div0      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= state == DONE && !(out_valid && out_ready);
            if (state == IDLE && in_valid) begin
                sign     <= num[DWIDTH-1] ^ den[DWIDTH-1];
                num_neg  <= num[DWIDTH-1];
                zero_den <= den == '0;
                den_mag  <= den_mag_in;
                rem      <= '0;
                acc      <= QW'(num_mag) << FRAC;
                iter     <= '0;
            end
            if (state == CALC) begin
                rem  <= rem_nx;
                acc  <= {acc[QW-2:0], q_bit};
                iter <= iter + 1'b1;
            end
            if (state == FIX) begin
                quot <= res;
                sat  <= zero_den || ovf;
                div0 <= zero_den;
            end
        end
    end

endmodule

// File: tb/tb_fxp_divider.sv
// tb_fxp_divider: directed checks of the fixed-point divider against hand-computed quotients
module tb_fxp_divider;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, sat, div0;
    logic [15:0] num, den, quot;
    int          checks = 0;
    int          errors = 0;

    fxp_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .sat       (sat),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one operation; hold>0 keeps out_ready low that many cycles after out_valid
    task automatic run_op(input logic [15:0] n, input logic [15:0] d, input logic [15:0] eq,
                          input logic es, input logic ed, input int elat, input int hold);
        int lat;
        @(negedge clk);
        check("in_ready", in_ready, 1);
        out_ready = hold == 0;
        num = n;
        den = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num = 16'h1234;
        den = 16'h0000;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 100);
        check("latency", lat, elat);
        check("quot", quot, eq);
        check("sat", sat, es);
        check("div0", div0, ed);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            num = 16'h4000;
            den = 16'h2000;
            @(posedge clk);
            #1;
            check("bp_quot", quot, eq);
            check("bp_flags", {out_valid, sat, div0, in_ready}, {1'b1, es, ed, 1'b0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("out_valid_clr", out_valid, 0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        num = '0;
        den = '0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_outs", {out_valid, sat, div0, quot}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        run_op(16'h00E1, 16'h4000, 16'h01C2, 0, 0, 33, 0);
        run_op(16'h2000, 16'h4000, 16'h4000, 0, 0, 33, 0);
        run_op(16'hE000, 16'h4000, 16'hC000, 0, 0, 33, 0);
        run_op(16'h2000, 16'hC000, 16'hC000, 0, 0, 33, 0);
        run_op(16'h4000, 16'h2000, 16'h7FFF, 1, 0, 33, 0);
        run_op(16'hC000, 16'h2000, 16'h8000, 1, 0, 33, 0);
        run_op(16'h8000, 16'h8000, 16'h7FFF, 1, 0, 33, 0);
        run_op(16'hC000, 16'h4000, 16'h8000, 0, 0, 33, 0);
        run_op(16'h0000, 16'h4000, 16'h0000, 0, 0, 33, 0);
        run_op(16'h0001, 16'h3000, 16'h0002, 0, 0, 33, 0);
        run_op(16'hFFFF, 16'h3000, 16'hFFFE, 0, 0, 33, 0);
        run_op(16'h00E1, 16'h0000, 16'h7FFF, 1, 1, 2, 0);
        run_op(16'hFF7D, 16'h0000, 16'h8000, 1, 1, 2, 0);
        run_op(16'h2000, 16'h4000, 16'h4000, 0, 0, 33, 5);
        run_op(16'hE000, 16'h4000, 16'hC000, 0, 0, 33, 0);
        run_op(16'hFF7D, 16'h0000, 16'h8000, 1, 1, 2, 0);

        // abort mid-calculation: quot/flags still hold the previous div0 result
        @(negedge clk);
        num = 16'h2000;
        den = 16'h4000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_outs", {out_valid, sat, div0, quot}, 0);
        check("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready_rel", in_ready, 1);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);

        run_op(16'h2000, 16'h4000, 16'h4000, 0, 0, 33, 0);
        run_op(16'h00E1, 16'h4000, 16'h01C2, 0, 0, 33, 0);
        run_op(16'h8000, 16'h4000, 16'h8000, 1, 0, 33, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
